conv_window_tracker: RTL

Output-side sequencer for the sliding-window convolution pipeline. It counts pixels entering the line-buffer and MAC chain, and marks which pipeline results are real KxK windows lying wholly inside the image at the configured stride. Wrap-around windows that straddle a row boundary are discarded. It produces a one-cycle result strobe, output coordinates, an end-of-frame strobe and a busy flag, all aligned to the pipeline's fixed latency.

---
 rtl/conv_window_tracker.sv | 96 +++++++++
 1 files changed

// File: rtl/conv_window_tracker.sv
// conv_window_tracker: marks legal strided KxK windows on a streaming frame and aligns strobes to the pipeline latency
module conv_window_tracker #(
  parameter int N = 5,
  parameter int K = 3,
  parameter int S = 1,
  parameter int LAT = 2,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          valid_conv,
  output logic          end_conv,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy
);
  localparam int M = (N - K) / S + 1;
  localparam int PW = S > 1 ? $clog2(S) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(N - 1);
  localparam logic [CW-1:0] K_M1 = CW'(K - 1);
  localparam logic [CW-1:0] C_LAST = CW'(K - 1 + S * (M - 1));
  localparam logic [PW-1:0] P_MAX = PW'(S - 1);
  typedef struct packed {
    logic          legal;
    logic          last;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } entry_t;
  typedef enum logic {IDLE, RUN} state_t;
  logic [CW-1:0] c, r, ocol, orow;
  logic [PW-1:0] cph, rph;
  logic          c_end, r_end, pix0, nf, nf_d;
  state_t        state, state_d;
  entry_t        in_e;
  entry_t        src  [LAT];
  entry_t        pipe [LAT];
  assign c_end = c == C_MAX;
  assign r_end = r == C_MAX;
  assign pix0  = ce && c == '0 && r == '0;
  // Stride phases are zero exactly on window-completing columns/rows once past K-1
  always_comb begin
    in_e.legal = ce && c >= K_M1 && r >= K_M1 && cph == '0 && rph == '0;
    in_e.last  = in_e.legal && c == C_LAST && r == C_LAST;
    in_e.row   = orow;
    in_e.col   = ocol;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c    <= '0;
      r    <= '0;
      cph  <= '0;
      rph  <= '0;
      ocol <= '0;
      orow <= '0;
    end else if (ce) begin
      c    <= c_end ? '0 : c + 1'b1;
      cph  <= (c_end || c < K_M1 || cph == P_MAX) ? '0 : cph + 1'b1;
      ocol <= c_end ? '0 : (c >= K_M1 && cph == P_MAX) ? ocol + 1'b1 : ocol;
      if (c_end) begin
        r    <= r_end ? '0 : r + 1'b1;
        rph  <= (r_end || r < K_M1 || rph == P_MAX) ? '0 : rph + 1'b1;
        orow <= r_end ? '0 : (r >= K_M1 && rph == P_MAX) ? orow + 1'b1 : orow;
      end
    end
  always_comb begin
    src[0] = in_e;
    for (int i = 1; i < LAT; i++) src[i] = pipe[i-1];
  end
  // Final stage keeps the last strobed coordinates when no legal window arrives
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      for (int i = 0; i < LAT - 1; i++) pipe[i] <= src[i];
      pipe[LAT-1] <= src[LAT-1].legal ? src[LAT-1] : {2'b00, pipe[LAT-1].row, pipe[LAT-1].col};
    end
  assign valid_conv = pipe[LAT-1].legal;
  assign end_conv   = pipe[LAT-1].last;
  assign out_row    = pipe[LAT-1].row;
  assign out_col    = pipe[LAT-1].col;
  assign busy       = state == RUN;
  // nf remembers a next-frame pixel 0 accepted before the current frame's end_conv emerged
  always_comb begin
    state_d = state == IDLE ? (pix0 ? RUN : IDLE) : (end_conv && !nf && !pix0) ? IDLE : RUN;
    nf_d    = state == RUN && !end_conv && (nf || pix0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      nf    <= 1'b0;
    end else begin
      state <= state_d;
      nf    <= nf_d;
    end
endmodule
